ahb_master: RTL and testbench

AHB-Lite bus master that turns simple command requests into pipelined AHB transfers toward `ahb_slave`. It sits directly upstream of the slave and drives its address/control/write-data inputs. It captures read data and error responses from the slave. Supported transfers: SINGLE, INCR (1–16 beats), INCR4 and WRAP4, with BUSY insertion when write data starves.

---
 rtl/ahb_master.sv | 248 ++++++++++++++++++++++++
 tb/tb_ahb_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master.sv
// AHB-Lite master: turns single commands into pipelined SINGLE/INCR/INCR4/WRAP4
// transfers, with a one-entry write-data buffer and BUSY insertion on underrun.
module ahb_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MAX_LEN = 16
) (
   input  logic              clk,
   input  logic              hreset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_write,
   input  logic [2:0]        cmd_burst,
   input  logic [4:0]        cmd_len,
   input  logic [2:0]        cmd_size,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [DATA_W-1:0] wdata,
   output logic              rdata_valid,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_last,
   output logic              done,
   output logic              err,
   output logic              hsel,
   output logic [ADDR_W-1:0] haddr,
   output logic              hwrite,
   output logic [2:0]        hsize,
   output logic [2:0]        hburst,
   output logic [1:0]        htrans,
   output logic [DATA_W-1:0] hwdata,
   input  logic              hready,
   input  logic              hresp,
   input  logic [DATA_W-1:0] hrdata
);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_BUSY   = 2'b01;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;
   localparam logic [2:0] BU_SINGLE = 3'b000;
   localparam logic [2:0] BU_INCR   = 3'b001;
   localparam logic [2:0] BU_WRAP4  = 3'b010;
   localparam logic [2:0] BU_INCR4  = 3'b011;
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [4:0] MAX_BEATS = 5'(MAX_LEN);

   typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_BURST, ST_LAST, ST_ERR} state_t;

   state_t            state_reg;
   logic [4:0]        beats_reg;
   logic              dph_valid_reg;
   logic              dph_last_reg;
   logic [DATA_W-1:0] wbuf_reg;
   logic [DATA_W-1:0] stage_reg;

   logic              wb_avail;
   logic [DATA_W-1:0] wb_data;
   logic              take_wb;
   logic [ADDR_W-1:0] step;
   logic [ADDR_W-1:0] addr_inc;
   logic [ADDR_W-1:0] wrap_mask;
   logic [ADDR_W-1:0] addr_next;
   logic              incr_burst;
   logic              next_nonseq;
   logic              can_issue;
   logic              accepted;
   logic              bus_err;
   logic [4:0]        cmd_beats;
   logic [2:0]        cmd_hburst;

   always_comb begin
      // An empty buffer can still feed an issue decision by bypassing the incoming beat.
      wb_avail    = ~wdata_ready | wdata_valid;
      wb_data     = wdata_ready ? wdata : wbuf_reg;
      step        = ADDR_ONE << hsize;
      addr_inc    = haddr + step;
      wrap_mask   = (step << 2) - ADDR_ONE;
      addr_next   = (hburst == BU_WRAP4) ? ((haddr & ~wrap_mask) | (addr_inc & wrap_mask))
                                         : addr_inc;
      incr_burst  = (hburst == BU_INCR) || (hburst == BU_INCR4);
      next_nonseq = incr_burst && (addr_next[9:0] == 10'd0);
      can_issue   = ~hwrite | wb_avail;
      accepted    = htrans[1];
      bus_err     = dph_valid_reg & hresp;

      cmd_hburst = BU_SINGLE;
      cmd_beats  = 5'd1;
      case (cmd_burst)
         BU_INCR: begin
            cmd_hburst = BU_INCR;
            if (cmd_len == 5'd0)
               cmd_beats = 5'd1;
            else if (cmd_len > MAX_BEATS)
               cmd_beats = MAX_BEATS;
            else
               cmd_beats = cmd_len;
         end
         BU_WRAP4: begin
            cmd_hburst = BU_WRAP4;
            cmd_beats  = 5'd4;
         end
         BU_INCR4: begin
            cmd_hburst = BU_INCR4;
            cmd_beats  = 5'd4;
         end
         default: ;
      endcase

      take_wb = 1'b0;
      case (state_reg)
         ST_IDLE: take_wb = cmd_valid & cmd_write & wb_avail;
         ST_ADDR, ST_BURST:
            if (hready && !bus_err)
               take_wb = hwrite & wb_avail & (~accepted | (beats_reg != 5'd1));
         default: ;
      endcase
   end

   // Write-data buffer; stage_reg holds the beat whose address phase is on the bus.
   always_ff @(posedge clk) begin
      if (hreset) begin
         wdata_ready <= 1'b1;
         wbuf_reg    <= '0;
         stage_reg   <= '0;
      end else if (take_wb) begin
         wdata_ready <= 1'b1;
         stage_reg   <= wb_data;
      end else if (wdata_valid && wdata_ready) begin
         wbuf_reg    <= wdata;
         wdata_ready <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (hreset) begin
         state_reg     <= ST_IDLE;
         beats_reg     <= '0;
         dph_valid_reg <= 1'b0;
         dph_last_reg  <= 1'b0;
         htrans        <= TR_IDLE;
         haddr         <= '0;
         hwrite        <= 1'b0;
         hsize         <= '0;
         hburst        <= '0;
         hwdata        <= '0;
         hsel          <= 1'b0;
         cmd_ready     <= 1'b1;
         rdata_valid   <= 1'b0;
         rdata         <= '0;
         rdata_last    <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         rdata_valid <= 1'b0;
         done        <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (cmd_valid) begin
                  state_reg     <= ST_ADDR;
                  cmd_ready     <= 1'b0;
                  haddr         <= cmd_addr;
                  hwrite        <= cmd_write;
                  hsize         <= cmd_size;
                  hburst        <= cmd_hburst;
                  beats_reg     <= cmd_beats;
                  dph_valid_reg <= 1'b0;
                  if (~cmd_write | wb_avail) begin
                     htrans <= TR_NONSEQ;
                     hsel   <= 1'b1;
                  end
               end
            end
            ST_ADDR, ST_BURST, ST_LAST: begin
               if (bus_err && !hready) begin
                  // First ERROR cycle: withdraw any pending address phase.
                  htrans    <= TR_IDLE;
                  state_reg <= ST_ERR;
               end else if (hready) begin
                  if (bus_err) begin
                     htrans        <= TR_IDLE;
                     hsel          <= 1'b0;
                     cmd_ready     <= 1'b1;
                     done          <= 1'b1;
                     err           <= 1'b1;
                     dph_valid_reg <= 1'b0;
                     state_reg     <= ST_IDLE;
                  end else begin
                     if (dph_valid_reg && !hwrite) begin
                        rdata       <= hrdata;
                        rdata_valid <= 1'b1;
                        rdata_last  <= dph_last_reg;
                     end
                     if (state_reg == ST_LAST) begin
                        hsel          <= 1'b0;
                        cmd_ready     <= 1'b1;
                        done          <= 1'b1;
                        err           <= 1'b0;
                        dph_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                     end else if (accepted) begin
                        dph_valid_reg <= 1'b1;
                        dph_last_reg  <= (beats_reg == 5'd1);
                        beats_reg     <= beats_reg - 5'd1;
                        if (hwrite)
                           hwdata <= stage_reg;
                        if (beats_reg == 5'd1) begin
                           htrans    <= TR_IDLE;
                           state_reg <= ST_LAST;
                        end else begin
                           haddr     <= addr_next;
                           state_reg <= ST_BURST;
                           if (can_issue)
                              htrans <= next_nonseq ? TR_NONSEQ : TR_SEQ;
                           else
                              htrans <= TR_BUSY;
                        end
                     end else begin
                        // Waiting for write data: IDLE before the first beat, BUSY afterwards.
                        dph_valid_reg <= 1'b0;
                        if (can_issue) begin
                           hsel <= 1'b1;
                           if (state_reg == ST_ADDR || (incr_burst && haddr[9:0] == 10'd0))
                              htrans <= TR_NONSEQ;
                           else
                              htrans <= TR_SEQ;
                        end
                     end
                  end
               end
            end
            ST_ERR: begin
               if (hready) begin
                  htrans        <= TR_IDLE;
                  hsel          <= 1'b0;
                  cmd_ready     <= 1'b1;
                  done          <= 1'b1;
                  err           <= 1'b1;
                  dph_valid_reg <= 1'b0;
                  state_reg     <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_master.sv
// Directed bench for ahb_master: the bench plays the slave and checks bus and
// command-side outputs cycle by cycle against hand-computed values.
module tb_ahb_master;

   logic        clk = 1'b0;
   logic        hreset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic        cmd_write;
   logic [2:0]  cmd_burst;
   logic [4:0]  cmd_len;
   logic [2:0]  cmd_size;
   logic        wdata_valid;
   logic        wdata_ready;
   logic [31:0] wdata;
   logic        rdata_valid;
   logic [31:0] rdata;
   logic        rdata_last;
   logic        done;
   logic        err;
   logic        hsel;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [1:0]  htrans;
   logic [31:0] hwdata;
   logic        hready;
   logic        hresp;
   logic [31:0] hrdata;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ahb_master #(.ADDR_W(32), .DATA_W(32), .MAX_LEN(16)) dut (
      .clk(clk), .hreset(hreset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_write(cmd_write), .cmd_burst(cmd_burst), .cmd_len(cmd_len), .cmd_size(cmd_size),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
      .done(done), .err(err), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
      .hsize(hsize), .hburst(hburst), .htrans(htrans), .hwdata(hwdata),
      .hready(hready), .hresp(hresp), .hrdata(hrdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cmd(input logic [31:0] a, input logic w, input logic [2:0] b, input logic [4:0] l);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_write = w;
      cmd_burst = b;
      cmd_len   = l;
      cmd_size  = 3'd2;
   endtask

   initial begin
      hreset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
      cmd_burst = '0; cmd_len = '0; cmd_size = '0; wdata_valid = 1'b0; wdata = '0;
      hready = 1'b1; hresp = 1'b0; hrdata = '0;
      tick(); tick();
      chk("rst_htrans", 32'(htrans), 0);
      chk("rst_haddr", haddr, 0);
      chk("rst_hsel", 32'(hsel), 0);
      chk("rst_cmd_ready", 32'(cmd_ready), 1);
      chk("rst_wdata_ready", 32'(wdata_ready), 1);
      chk("rst_done", 32'(done), 0);
      chk("rst_rdata_valid", 32'(rdata_valid), 0);
      chk("rst_hwdata", hwdata, 0);
      hreset = 1'b0;

      // SINGLE write 0xA5 to 0x10
      wdata_valid = 1'b1; wdata = 32'hA5;
      cmd(32'h10, 1'b1, 3'b000, 5'd0);
      tick();
      cmd_valid = 1'b0; wdata_valid = 1'b0;
      chk("single_nonseq", 32'(htrans), 2);
      chk("single_addr", haddr, 32'h10);
      chk("single_hwrite", 32'(hwrite), 1);
      chk("single_hsel", 32'(hsel), 1);
      chk("single_cmd_ready", 32'(cmd_ready), 0);
      tick();
      chk("single_idle", 32'(htrans), 0);
      chk("single_hwdata", hwdata, 32'hA5);
      tick();
      chk("single_done", 32'(done), 1);
      chk("single_err", 32'(err), 0);
      chk("single_hsel_off", 32'(hsel), 0);
      chk("single_cmd_ready_back", 32'(cmd_ready), 1);
      tick();
      chk("single_done_pulse", 32'(done), 0);

      // INCR4 read from 0x20, slave returns addr+1
      cmd(32'h20, 1'b0, 3'b011, 5'd0);
      tick();
      cmd_valid = 1'b0;
      chk("incr4r_nonseq", 32'(htrans), 2);
      chk("incr4r_a0", haddr, 32'h20);
      chk("incr4r_hburst", 32'(hburst), 3);
      tick();
      chk("incr4r_seq1", 32'(htrans), 3);
      chk("incr4r_a1", haddr, 32'h24);
      hrdata = 32'h21;
      tick();
      chk("incr4r_rv0", 32'(rdata_valid), 1);
      chk("incr4r_rd0", rdata, 32'h21);
      chk("incr4r_last0", 32'(rdata_last), 0);
      chk("incr4r_a2", haddr, 32'h28);
      hrdata = 32'h25;
      tick();
      chk("incr4r_rd1", rdata, 32'h25);
      chk("incr4r_a3", haddr, 32'h2C);
      chk("incr4r_seq3", 32'(htrans), 3);
      hrdata = 32'h29;
      tick();
      chk("incr4r_rd2", rdata, 32'h29);
      chk("incr4r_idle", 32'(htrans), 0);
      hrdata = 32'h2D;
      tick();
      chk("incr4r_rd3", rdata, 32'h2D);
      chk("incr4r_rv3", 32'(rdata_valid), 1);
      chk("incr4r_last3", 32'(rdata_last), 1);
      chk("incr4r_done", 32'(done), 1);

      // WRAP4 write from 0x38, data 1..4
      cmd(32'h38, 1'b1, 3'b010, 5'd0);
      wdata_valid = 1'b1; wdata = 32'd1;
      tick();
      cmd_valid = 1'b0; wdata = 32'd2;
      chk("wrap4w_nonseq", 32'(htrans), 2);
      chk("wrap4w_a0", haddr, 32'h38);
      tick();
      chk("wrap4w_a1", haddr, 32'h3C);
      chk("wrap4w_seq", 32'(htrans), 3);
      chk("wrap4w_d0", hwdata, 32'd1);
      wdata = 32'd3;
      tick();
      chk("wrap4w_a2", haddr, 32'h30);
      chk("wrap4w_d1", hwdata, 32'd2);
      wdata = 32'd4;
      tick();
      chk("wrap4w_a3", haddr, 32'h34);
      chk("wrap4w_d2", hwdata, 32'd3);
      wdata_valid = 1'b0;
      tick();
      chk("wrap4w_d3", hwdata, 32'd4);
      chk("wrap4w_idle", 32'(htrans), 0);
      tick();
      chk("wrap4w_done", 32'(done), 1);

      // INCR4 write with wait states and a write-data underrun
      cmd(32'h0, 1'b1, 3'b011, 5'd0);
      wdata_valid = 1'b1; wdata = 32'h11;
      tick();
      cmd_valid = 1'b0; wdata = 32'h22;
      chk("wait_nonseq", 32'(htrans), 2);
      tick();
      chk("wait_a1", haddr, 32'h04);
      chk("wait_d0", hwdata, 32'h11);
      wdata = 32'h33;
      tick();
      chk("wait_a2", haddr, 32'h08);
      chk("wait_d1", hwdata, 32'h22);
      hready = 1'b0; wdata_valid = 1'b0;
      tick();
      chk("hold1_addr", haddr, 32'h08);
      chk("hold1_trans", 32'(htrans), 3);
      chk("hold1_hwdata", hwdata, 32'h22);
      tick();
      chk("hold2_addr", haddr, 32'h08);
      chk("hold2_trans", 32'(htrans), 3);
      hready = 1'b1;
      tick();
      chk("busy_trans", 32'(htrans), 1);
      chk("busy_addr", haddr, 32'h0C);
      chk("busy_d2", hwdata, 32'h33);
      wdata_valid = 1'b1; wdata = 32'h44;
      tick();
      chk("resume_seq", 32'(htrans), 3);
      chk("resume_addr", haddr, 32'h0C);
      wdata_valid = 1'b0;
      tick();
      chk("wait_d3", hwdata, 32'h44);
      chk("wait_idle", 32'(htrans), 0);
      tick();
      chk("wait_done", 32'(done), 1);
      chk("wait_err", 32'(err), 0);

      // INCR len 3 across a 1 KB boundary
      cmd(32'h3F8, 1'b0, 3'b001, 5'd3);
      tick();
      cmd_valid = 1'b0;
      chk("kb_nonseq0", 32'(htrans), 2);
      chk("kb_a0", haddr, 32'h3F8);
      tick();
      chk("kb_seq1", 32'(htrans), 3);
      chk("kb_a1", haddr, 32'h3FC);
      tick();
      chk("kb_nonseq2", 32'(htrans), 2);
      chk("kb_a2", haddr, 32'h400);
      chk("kb_hburst", 32'(hburst), 1);
      tick();
      chk("kb_idle", 32'(htrans), 0);
      tick();
      chk("kb_done", 32'(done), 1);

      // WRAP4 read with ERROR on beat 2
      cmd(32'h48, 1'b0, 3'b010, 5'd0);
      tick();
      cmd_valid = 1'b0;
      chk("errr_a0", haddr, 32'h48);
      tick();
      chk("errr_a1", haddr, 32'h4C);
      hrdata = 32'h1111;
      tick();
      chk("errr_rv0", 32'(rdata_valid), 1);
      chk("errr_rd0", rdata, 32'h1111);
      chk("errr_a2", haddr, 32'h40);
      chk("errr_seq2", 32'(htrans), 3);
      hready = 1'b0; hresp = 1'b1; hrdata = 32'hBAD;
      tick();
      chk("errr_idle", 32'(htrans), 0);
      chk("errr_no_rv", 32'(rdata_valid), 0);
      chk("errr_no_done_yet", 32'(done), 0);
      hready = 1'b1;
      tick();
      chk("errr_done", 32'(done), 1);
      chk("errr_err", 32'(err), 1);
      chk("errr_hsel", 32'(hsel), 0);
      chk("errr_no_rv2", 32'(rdata_valid), 0);
      hresp = 1'b0;
      tick();
      chk("errr_stay_idle", 32'(htrans), 0);
      chk("errr_done_pulse", 32'(done), 0);
      chk("errr_cmd_ready", 32'(cmd_ready), 1);

      // Reset asserted mid-burst
      cmd(32'h48, 1'b0, 3'b010, 5'd0);
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("mid_hsel", 32'(hsel), 1);
      chk("mid_addr", haddr, 32'h4C);
      hreset = 1'b1;
      tick();
      chk("mrst_htrans", 32'(htrans), 0);
      chk("mrst_haddr", haddr, 0);
      chk("mrst_hsel", 32'(hsel), 0);
      chk("mrst_cmd_ready", 32'(cmd_ready), 1);
      chk("mrst_rdata", rdata, 0);
      chk("mrst_hburst", 32'(hburst), 0);
      chk("mrst_done", 32'(done), 0);
      chk("mrst_wdata_ready", 32'(wdata_ready), 1);
      hreset = 1'b0;
      tick();
      chk("mrst_no_done", 32'(done), 0);
      chk("mrst_still_idle", 32'(htrans), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
